// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache/memory port arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
interface cache_mem_arbiter_if #(
    parameter int WIDTH = 32
);

    logic             if_req_i;
    logic [WIDTH-1:0] if_addr_i;
    logic             if_ready_o;
    logic [WIDTH-1:0] if_rdata_o;

    logic             d_req_i;
    logic             d_we_i;
    logic             d_byte_op_i;
    logic [WIDTH-1:0] d_addr_i;
    logic [WIDTH-1:0] d_wdata_i;
    logic             d_ready_o;
    logic [WIDTH-1:0] d_rdata_o;

    logic             mem_req_o;
    logic             mem_we_o;
    logic             mem_byte_op_o;
    logic [WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0] mem_wdata_o;
    logic             mem_ack_i;
    logic [WIDTH-1:0] mem_rdata_i;

    logic             err_o;

    // Environment view: the fetch/load-store units plus the memory
    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_byte_op_i, d_addr_i, d_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  if_ready_o, if_rdata_o, d_ready_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o,
        input  err_o
    );

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_byte_op_i, d_addr_i, d_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output if_ready_o, if_rdata_o, d_ready_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o,
        output err_o
    );

endinterface

// File: rtl/arb_watchdog.sv
// Clear/enable cycle counter that flags when a memory transaction has waited TIMEOUT cycles.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Saturates at LAST so the count can never wrap inside one transaction
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= '0;
        end else if (enable_i && !expired_o) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired_o = (r_count == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a watchdog that aborts transactions the memory never acknowledges.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cache_mem_arbiter_if.slave bus
);

    arb_state_t       r_state,     w_state;
    owner_t           r_owner,     w_owner;
    owner_t           r_lastGrant, w_lastGrant;
    logic             r_memReq,    w_memReq;
    logic             r_memWe,     w_memWe;
    logic             r_memByteOp, w_memByteOp;
    logic [WIDTH-1:0] r_memAddr,   w_memAddr;
    logic [WIDTH-1:0] r_memWdata,  w_memWdata;
    logic             r_ifReady,   w_ifReady;
    logic             r_dReady,    w_dReady;
    logic [WIDTH-1:0] r_ifRdata,   w_ifRdata;
    logic [WIDTH-1:0] r_dRdata,    w_dRdata;
    logic             r_err,       w_err;

    owner_t w_winner;
    logic   w_grant;
    logic   w_wdEnable;
    logic   w_wdExpired;

    assign w_wdEnable = (r_state == BUSY) && !bus.mem_ack_i;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_grant),
        .enable_i  (w_wdEnable),
        .expired_o (w_wdExpired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_lastGrant <= OWN_IF;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memByteOp <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_ifReady   <= 1'b0;
            r_dReady    <= 1'b0;
            r_ifRdata   <= '0;
            r_dRdata    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_owner     <= w_owner;
            r_lastGrant <= w_lastGrant;
            r_memReq    <= w_memReq;
            r_memWe     <= w_memWe;
            r_memByteOp <= w_memByteOp;
            r_memAddr   <= w_memAddr;
            r_memWdata  <= w_memWdata;
            r_ifReady   <= w_ifReady;
            r_dReady    <= w_dReady;
            r_ifRdata   <= w_ifRdata;
            r_dRdata    <= w_dRdata;
            r_err       <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_owner     = r_owner;
        w_lastGrant = r_lastGrant;
        w_memReq    = r_memReq;
        w_memWe     = r_memWe;
        w_memByteOp = r_memByteOp;
        w_memAddr   = r_memAddr;
        w_memWdata  = r_memWdata;
        w_ifRdata   = r_ifRdata;
        w_dRdata    = r_dRdata;
        w_err       = r_err;
        w_ifReady   = 1'b0;
        w_dReady    = 1'b0;
        w_grant     = 1'b0;
        w_winner    = OWN_IF;

        // Under contention the requester that did not win last time goes first
        if (bus.if_req_i && bus.d_req_i) begin
            w_winner = (r_lastGrant == OWN_IF) ? OWN_D : OWN_IF;
        end else if (bus.d_req_i) begin
            w_winner = OWN_D;
        end

        case (r_state)
            IDLE: begin
                if (bus.if_req_i || bus.d_req_i) begin
                    w_grant     = 1'b1;
                    w_state     = BUSY;
                    w_owner     = w_winner;
                    w_lastGrant = w_winner;
                    w_memReq    = 1'b1;
                    if (w_winner == OWN_D) begin
                        w_memWe     = bus.d_we_i;
                        w_memByteOp = bus.d_byte_op_i;
                        w_memAddr   = bus.d_addr_i;
                        w_memWdata  = bus.d_wdata_i;
                    end else begin
                        w_memWe     = 1'b0;
                        w_memByteOp = 1'b0;
                        w_memAddr   = bus.if_addr_i;
                        w_memWdata  = '0;
                    end
                end
            end
            BUSY: begin
                // An ack in the watchdog's final cycle still completes normally
                if (bus.mem_ack_i || w_wdExpired) begin
                    w_memReq = 1'b0;
                    w_state  = RESP;
                    if (!bus.mem_ack_i) begin
                        w_err = 1'b1;
                    end
                    if (r_owner == OWN_IF) begin
                        w_ifReady = 1'b1;
                        w_ifRdata = bus.mem_ack_i ? bus.mem_rdata_i : '0;
                    end else begin
                        w_dReady = 1'b1;
                        w_dRdata = (bus.mem_ack_i && !r_memWe) ? bus.mem_rdata_i : '0;
                    end
                end
            end
            RESP: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.if_ready_o    = r_ifReady;
    assign bus.if_rdata_o    = r_ifRdata;
    assign bus.d_ready_o     = r_dReady;
    assign bus.d_rdata_o     = r_dRdata;
    assign bus.mem_req_o     = r_memReq;
    assign bus.mem_we_o      = r_memWe;
    assign bus.mem_byte_op_o = r_memByteOp;
    assign bus.mem_addr_o    = r_memAddr;
    assign bus.mem_wdata_o   = r_memWdata;
    assign bus.err_o         = r_err;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: drivers queue expected responses, monitors
// compare grants and completions against a round-robin reference model.
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [31:0] rdata;
        bit          timeout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

    cache_mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int     checkCount = 0;
    int     passCount  = 0;
    exp_t   ifExp[$];
    exp_t   dExp[$];
    owner_t grantLog[$];
    owner_t lastGrantModel = OWN_IF;
    bit     errModel       = 1'b0;
    bit     memMute        = 1'b0;
    bit     spurAck        = 1'b0;
    int     ackDelayFixed  = -1;
    int     lastReqLen     = 0;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    function automatic void failNow(string name);
        checkCount++;
        $display("[TB] FAIL %s: wait bound expired or unexpected event", name);
    endfunction

    // Contents of the simulated memory, a fixed function of the address
    function automatic logic [31:0] memData(logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic void resetModel();
        ifExp.delete();
        dExp.delete();
        grantLog.delete();
        lastGrantModel = OWN_IF;
        errModel       = 1'b0;
    endfunction

    // Memory model: acks a pending request after a chosen number of waiting cycles
    initial begin
        int waitCnt;
        int curDelay;
        waitCnt = 0;
        curDelay = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack_i = 1'b0;
            if (!bus.mem_req_o) begin
                waitCnt  = 0;
                curDelay = (ackDelayFixed >= 0) ? ackDelayFixed : int'($urandom_range(0, 4));
            end else if (!memMute) begin
                if (waitCnt >= curDelay) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = memData(bus.mem_addr_o);
                    waitCnt = 0;
                    curDelay = 1000;
                end else begin
                    waitCnt++;
                end
            end
            if (spurAck) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = $urandom;
            end
        end
    end

    // Completion monitor: pops the owner's queue on every ready pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_ready_o && bus.d_ready_o) failNow("bothReady");
            if (bus.if_ready_o) begin
                if (ifExp.size() == 0) failNow("unexpectedIfReady");
                else begin
                    e = ifExp.pop_front();
                    checkOutput("ifRdata", bus.if_rdata_o, e.rdata);
                    if (e.timeout) errModel = 1'b1;
                    checkOutput("ifErr", 32'(bus.err_o), 32'(errModel));
                end
            end
            if (bus.d_ready_o) begin
                if (dExp.size() == 0) failNow("unexpectedDReady");
                else begin
                    e = dExp.pop_front();
                    checkOutput("dRdata", bus.d_rdata_o, e.rdata);
                    if (e.timeout) errModel = 1'b1;
                    checkOutput("dErr", 32'(bus.err_o), 32'(errModel));
                end
            end
        end
    end

    // Grant monitor: predicts the winner from the requests seen at the grant edge
    initial begin
        logic        prevReq, sIfReq, sDReq, sDWe, sDByte;
        logic [31:0] sIfAddr, sDAddr, sDWdata, expAddr;
        owner_t      win;
        int          reqLen;
        prevReq = 1'b0;
        reqLen  = 0;
        expAddr = '0;
        forever begin
            @(posedge clk);
            sIfReq  = bus.if_req_i;
            sIfAddr = bus.if_addr_i;
            sDReq   = bus.d_req_i;
            sDWe    = bus.d_we_i;
            sDByte  = bus.d_byte_op_i;
            sDAddr  = bus.d_addr_i;
            sDWdata = bus.d_wdata_i;
            @(negedge clk);
            if (bus.mem_req_o && !prevReq) begin
                if (!sIfReq && !sDReq) failNow("grantWithoutRequest");
                if (sIfReq && sDReq) win = (lastGrantModel == OWN_IF) ? OWN_D : OWN_IF;
                else win = sDReq ? OWN_D : OWN_IF;
                lastGrantModel = win;
                grantLog.push_back(win);
                if (win == OWN_D) begin
                    expAddr = sDAddr;
                    checkOutput("grantDWe", 32'(bus.mem_we_o), 32'(sDWe));
                    checkOutput("grantDByte", 32'(bus.mem_byte_op_o), 32'(sDByte));
                    checkOutput("grantDWdata", bus.mem_wdata_o, sDWdata);
                end else begin
                    expAddr = sIfAddr;
                    checkOutput("grantIfWe", 32'(bus.mem_we_o), 32'h0);
                    checkOutput("grantIfByte", 32'(bus.mem_byte_op_o), 32'h0);
                end
                checkOutput("grantAddr", bus.mem_addr_o, expAddr);
                reqLen = 1;
            end else if (bus.mem_req_o) begin
                reqLen++;
                checkOutput("holdAddr", bus.mem_addr_o, expAddr);
            end else if (prevReq) begin
                lastReqLen = reqLen;
            end
            prevReq = bus.mem_req_o;
        end
    end

    task automatic ifTxn(input logic [31:0] addr);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = addr;
        e.rdata   = memMute ? 32'h0 : memData(addr);
        e.timeout = memMute;
        ifExp.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.if_ready_o && n < 100);
        if (!bus.if_ready_o) failNow("ifReadyWait");
    endtask

    task automatic dTxn(input logic we, input logic byteOp, input logic [31:0] addr,
                        input logic [31:0] wdata);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        bus.d_req_i     = 1'b1;
        bus.d_we_i      = we;
        bus.d_byte_op_i = byteOp;
        bus.d_addr_i    = addr;
        bus.d_wdata_i   = wdata;
        e.rdata   = (memMute || we) ? 32'h0 : memData(addr);
        e.timeout = memMute;
        dExp.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.d_ready_o && n < 100);
        if (!bus.d_ready_o) failNow("dReadyWait");
    endtask

    task automatic ifIdle();
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic dIdle();
        @(posedge clk);
        #1;
        bus.d_req_i = 1'b0;
    endtask

    task automatic applyReset(input int cycles);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.if_req_i = 1'b0;
        bus.d_req_i  = 1'b0;
        resetModel();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        @(negedge clk);
        checkOutput({tag, "MemReq"}, 32'(bus.mem_req_o), 32'h0);
        checkOutput({tag, "MemWe"}, 32'(bus.mem_we_o), 32'h0);
        checkOutput({tag, "MemByte"}, 32'(bus.mem_byte_op_o), 32'h0);
        checkOutput({tag, "MemAddr"}, bus.mem_addr_o, 32'h0);
        checkOutput({tag, "MemWdata"}, bus.mem_wdata_o, 32'h0);
        checkOutput({tag, "IfReady"}, 32'(bus.if_ready_o), 32'h0);
        checkOutput({tag, "DReady"}, 32'(bus.d_ready_o), 32'h0);
        checkOutput({tag, "IfRdata"}, bus.if_rdata_o, 32'h0);
        checkOutput({tag, "DRdata"}, bus.d_rdata_o, 32'h0);
        checkOutput({tag, "Err"}, 32'(bus.err_o), 32'h0);
    endtask

    // Random concurrent traffic from both requesters with random gaps and ack delays
    task automatic applyStimulus(input int nTxn);
        ackDelayFixed = -1;
        fork
            begin
                for (int i = 0; i < nTxn; i++) begin
                    ifTxn({$urandom_range(0, 16'hFFFF), 2'b00});
                    if ($urandom_range(0, 1) == 1) begin
                        ifIdle();
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                    end
                end
                ifIdle();
            end
            begin
                for (int j = 0; j < nTxn; j++) begin
                    dTxn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        dIdle();
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                    end
                end
                dIdle();
            end
        join
    endtask

    initial begin
        #2000000;
        failNow("globalTimeLimit");
        $display("%0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        owner_t expOrder [4];
        expOrder = '{OWN_D, OWN_IF, OWN_D, OWN_IF};
        rst = 1'b1;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_byte_op_i = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_wdata_i   = '0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetOutputs("reset");

        $display("[TB] single fetch and single data write");
        ackDelayFixed = 2;
        ifTxn(32'h100);
        ifIdle();
        dTxn(1'b1, 1'b1, 32'h200, 32'h12345678);
        dIdle();

        $display("[TB] continuous contention after reset");
        applyReset(2);
        ackDelayFixed = 0;
        fork
            begin ifTxn(32'h1000); ifTxn(32'h1004); ifIdle(); end
            begin dTxn(1'b0, 1'b0, 32'h2000, 32'h0); dTxn(1'b1, 1'b0, 32'h2004, 32'hCAFE0001); dIdle(); end
        join
        if (grantLog.size() < 4) failNow("grantOrderCount");
        else for (int k = 0; k < 4; k++) checkOutput("grantOrder", 32'(grantLog[k]), 32'(expOrder[k]));

        $display("[TB] ack on the last watchdog cycle");
        ackDelayFixed = TIMEOUT - 1;
        ifTxn(32'h0000_0240);
        ifIdle();
        checkOutput("lateAckReqLen", lastReqLen, TIMEOUT);
        checkOutput("lateAckErr", 32'(bus.err_o), 32'h0);

        $display("[TB] memory never acks");
        memMute = 1'b1;
        dTxn(1'b0, 1'b0, 32'h340, 32'h0);
        dIdle();
        checkOutput("timeoutReqLen", lastReqLen, TIMEOUT);
        memMute = 1'b0;
        ackDelayFixed = 1;
        ifTxn(32'h380);
        ifIdle();
        checkOutput("errSticky", 32'(bus.err_o), 32'h1);

        $display("[TB] reset in the middle of a transaction");
        applyReset(2);
        memMute = 1'b1;
        @(posedge clk);
        #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h504;
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = 32'h500;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.if_req_i = 1'b0;
        bus.d_req_i  = 1'b0;
        resetModel();
        @(posedge clk);
        checkResetOutputs("midReset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        memMute = 1'b0;
        fork
            begin dTxn(1'b0, 1'b0, 32'h600, 32'h0); dIdle(); end
            begin ifTxn(32'h604); ifIdle(); end
        join
        if (grantLog.size() < 1) failNow("postResetGrant");
        else checkOutput("postResetWinner", 32'(grantLog[0]), 32'(OWN_D));

        $display("[TB] address change during busy and stray ack in idle");
        ackDelayFixed = 3;
        begin
            exp_t e;
            int   n;
            @(posedge clk);
            #1;
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = 32'h700;
            e.rdata   = memData(32'h700);
            e.timeout = 1'b0;
            ifExp.push_back(e);
            repeat (2) @(posedge clk);
            #1;
            bus.if_addr_i = 32'h7FC;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.if_ready_o && n < 100);
            if (!bus.if_ready_o) failNow("addrChangeReadyWait");
        end
        ifIdle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        spurAck = 1'b1;
        @(negedge clk);
        spurAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("strayAckMemReq", 32'(bus.mem_req_o), 32'h0);
            checkOutput("strayAckIfReady", 32'(bus.if_ready_o), 32'h0);
            checkOutput("strayAckDReady", 32'(bus.d_ready_o), 32'h0);
            checkOutput("strayAckAddr", bus.mem_addr_o, 32'h700);
        end

        $display("[TB] randomized traffic");
        applyStimulus(25);

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("ifQueueDrained", ifExp.size(), 32'h0);
        checkOutput("dQueueDrained", dExp.size(), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
